// File: rtl/mult_4x1_mux.sv
// rtl/mult_4x1_mux.sv - Clocked 4-to-1 selector with combinational preview and valid flag
//
// Purpose: selects one of i0..i3 by {s1,s0}. The selected value is presented
// combinationally on r_comb and captured into r on rising edges where
// in_valid is high. r_valid marks the cycle after each capture.
//
// Optional feature macro: MULT_4X1_SEL_TRACE_EN (adds sel_q / sel_chg).
//
// Parameters:
//   WIDTH    - data width of i0..i3, r, r_comb
//   RST_VAL  - value loaded into r while rst is high
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   i0..i3    in   WIDTH  data inputs ({s1,s0} = 00,01,10,11)
//   s0, s1    in   1      select LSB / MSB
//   in_valid  in   1      capture enable
//   r         out  WIDTH  registered selected value
//   r_valid   out  1      high for the cycle after a capture
//   r_comb    out  WIDTH  combinational selected value
//   sel_q     out  2      (trace only) select used by the last capture
//   sel_chg   out  1      (trace only) capture used a different select than sel_q

module mult_4x1_mux #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s0,
    input  logic             s1,
    input  logic             in_valid,
    output logic [WIDTH-1:0] r,
    output logic             r_valid,
    output logic [WIDTH-1:0] r_comb
`ifdef MULT_4X1_SEL_TRACE_EN
    ,
    output logic [1:0]       sel_q,
    output logic             sel_chg
`endif
);

    logic [1:0] w_sel;

    assign w_sel = {s1, s0};

    // An X/Z select matches none of the items, so simulation sees all-X.
    always_comb begin
        r_comb = 'x;
        case (w_sel)
            2'b00:   r_comb = i0;
            2'b01:   r_comb = i1;
            2'b10:   r_comb = i2;
            2'b11:   r_comb = i3;
            default: r_comb = 'x;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r       <= RST_VAL;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r <= r_comb;
            end
        end
    end

`ifdef MULT_4X1_SEL_TRACE_EN
    // r_seen blocks sel_chg on the first capture after reset, because the
    // reset value of sel_q is not a select that was actually used.
    logic r_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= 2'b00;
            sel_chg <= 1'b0;
            r_seen  <= 1'b0;
        end else begin
            sel_chg <= in_valid && r_seen && (w_sel != sel_q);
            if (in_valid) begin
                sel_q  <= w_sel;
                r_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult_4x1_mux.sv
// tb/tb_mult_4x1_mux.sv - Scoreboard testbench for mult_4x1_mux

module tb_mult_4x1_mux;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] i0, i1, i2, i3;
    logic         s0, s1;
    logic         in_valid;
    logic [W-1:0] r;
    logic         r_valid;
    logic [W-1:0] r_comb;
`ifdef MULT_4X1_SEL_TRACE_EN
    logic [1:0]   sel_q;
    logic         sel_chg;
`endif

    mult_4x1_mux #(.WIDTH(W), .RST_VAL(8'h00)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .i0       (i0),
        .i1       (i1),
        .i2       (i2),
        .i3       (i3),
        .s0       (s0),
        .s1       (s1),
        .in_valid (in_valid),
        .r        (r),
        .r_valid  (r_valid),
        .r_comb   (r_comb)
`ifdef MULT_4X1_SEL_TRACE_EN
        ,
        .sel_q    (sel_q),
        .sel_chg  (sel_chg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [W-1:0] r;
        logic [1:0]   sq;
        logic         chg;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference state: what the output register and select history should be.
    logic [W-1:0] m_r;
    logic [1:0]   m_sq;
    logic         m_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_r    = 8'h00;
        m_sq   = 2'b00;
        m_seen = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, check the preview, queue the registered result.
    task automatic cycle(input logic [1:0] sel, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] d3, input logic v);
        logic [W-1:0] d [4];
        exp_t e;
        @(negedge clk);
        i0 = d0; i1 = d1; i2 = d2; i3 = d3;
        {s1, s0} = sel;
        in_valid = v;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        #1;
        chk("r_comb", 32'(r_comb), 32'(d[sel]));
        e.v   = v;
        e.chg = 1'b0;
        if (v) begin
            e.chg  = m_seen && (sel != m_sq);
            m_r    = d[sel];
            m_sq   = sel;
            m_seen = 1'b1;
        end
        e.r  = m_r;
        e.sq = m_sq;
        exp_q.push_back(e);
    endtask

    // Reset asserted mid-cycle while a capture is pending.
    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        i0 = 8'hFF; i1 = 8'hFF; i2 = 8'hFF; i3 = 8'hFF;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_r", 32'(r), 32'(8'h00));
        chk("async_rst_valid", 32'(r_valid), 32'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        chk("held_rst_r", 32'(r), 32'(8'h00));
        chk("held_rst_valid", 32'(r_valid), 32'(1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
    endtask

    // Monitor: one expected entry is popped per clock edge after stimulus issue.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("r_valid", 32'(r_valid), 32'(e.v));
            chk("r", 32'(r), 32'(e.r));
`ifdef MULT_4X1_SEL_TRACE_EN
            chk("sel_q", 32'(sel_q), 32'(e.sq));
            chk("sel_chg", 32'(sel_chg), 32'(e.chg));
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i0 = '0; i1 = '0; i2 = '0; i3 = '0;
        s0 = 1'b0; s1 = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        chk("reset_r", 32'(r), 32'(8'h00));
        chk("reset_valid", 32'(r_valid), 32'(1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Get r=1, then reset in the middle of a pending capture.
        cycle(2'b00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
        do_reset();

        // One-hot walk, back-to-back captures.
        cycle(2'b00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
        cycle(2'b01, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1);
        cycle(2'b10, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1);
        cycle(2'b11, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);

        // Deselect: only the unselected input is high.
        cycle(2'b00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);

        // Hold: capture A5, then change i2 without in_valid.
        cycle(2'b10, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b1);
        cycle(2'b10, 8'h00, 8'h00, 8'h3C, 8'h00, 1'b0);
        cycle(2'b10, 8'h00, 8'h00, 8'h3C, 8'h00, 1'b0);

        // Select and data change together.
        cycle(2'b01, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        cycle(2'b11, 8'h11, 8'h22, 8'h33, 8'hFF, 1'b1);

        // Trace sequence after a fresh reset: selects 00, 00, 10.
        do_reset();
        cycle(2'b00, 8'h12, 8'h34, 8'h56, 8'h78, 1'b1);
        cycle(2'b00, 8'h9A, 8'h34, 8'h56, 8'h78, 1'b1);
        cycle(2'b10, 8'h9A, 8'h34, 8'hBC, 8'h78, 1'b1);

        // Randomized traffic with a reset in the middle.
        for (int n = 0; n < 300; n++) begin
            if (n == 150) do_reset();
            cycle(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
